// File: rtl/obj_affine_param_fetch.sv
// OBJ affine parameter fetch: caches one PA/PB/PC/PD group and refills it from OAM with four
// pipelined halfword reads whose returns are matched by a latency-deep tag shift register.
module obj_affine_param_fetch #(
  parameter int unsigned OAM_LAT = 1
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_group,
  input  logic        flush,
  output logic        oam_re,
  output logic [8:0]  oam_addr,
  input  logic [15:0] oam_rdata,
  output logic [15:0] pa,
  output logic [15:0] pb,
  output logic [15:0] pc,
  output logic [15:0] pd,
  output logic        params_valid
);

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  state_e             state_q, state_d;
  logic               cache_valid_q, cache_valid_d;
  logic [4:0]         cached_group_q, cached_group_d;
  logic               params_valid_q, params_valid_d;
  logic [2:0]         issue_cnt_q, issue_cnt_d;
  logic [1:0]         capture_cnt_q, capture_cnt_d;
  logic [OAM_LAT-1:0] pend_q, pend_d;
  logic [15:0]        pa_q, pa_d, pb_q, pb_d, pc_q, pc_d, pd_q, pd_d;

  logic accept, hit, capture;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cache_valid_q  <= 1'b0;
      cached_group_q <= 5'd0;
      params_valid_q <= 1'b0;
      issue_cnt_q    <= 3'd0;
      capture_cnt_q  <= 2'd0;
      pend_q         <= '0;
      pa_q           <= 16'h0100;
      pb_q           <= 16'h0000;
      pc_q           <= 16'h0000;
      pd_q           <= 16'h0100;
    end else begin
      cache_valid_q  <= cache_valid_d;
      cached_group_q <= cached_group_d;
      params_valid_q <= params_valid_d;
      issue_cnt_q    <= issue_cnt_d;
      capture_cnt_q  <= capture_cnt_d;
      pend_q         <= pend_d;
      pa_q           <= pa_d;
      pb_q           <= pb_d;
      pc_q           <= pc_d;
      pd_q           <= pd_d;
    end
  end

  assign accept  = req_valid && (state_q == StIdle);
  assign hit     = cache_valid_q && (req_group == cached_group_q) && !flush;
  // A flush cycle never captures: whatever returns then belongs to the abandoned pass.
  assign capture = (state_q == StFetch) && pend_q[OAM_LAT-1] && !flush;

  always_comb begin
    state_d        = state_q;
    cache_valid_d  = cache_valid_q;
    cached_group_d = cached_group_q;
    params_valid_d = params_valid_q;
    issue_cnt_d    = issue_cnt_q;
    capture_cnt_d  = capture_cnt_q;
    pend_d         = flush ? '0 : OAM_LAT'({pend_q, oam_re});
    pa_d           = pa_q;
    pb_d           = pb_q;
    pc_d           = pc_q;
    pd_d           = pd_q;
    unique case (state_q)
      StIdle: begin
        if (accept && hit) begin
          params_valid_d = 1'b1;
        end else if (accept) begin
          cached_group_d = req_group;
          cache_valid_d  = 1'b0;
          params_valid_d = 1'b0;
          issue_cnt_d    = 3'd0;
          capture_cnt_d  = 2'd0;
          state_d        = StFetch;
        end else if (flush) begin
          cache_valid_d  = 1'b0;
          params_valid_d = 1'b0;
        end
      end
      StFetch: begin
        if (flush) begin
          issue_cnt_d   = 3'd0;
          capture_cnt_d = 2'd0;
        end else begin
          if (oam_re) issue_cnt_d = issue_cnt_q + 3'd1;
          if (capture) begin
            capture_cnt_d = capture_cnt_q + 2'd1;
            unique case (capture_cnt_q)
              2'd0: pa_d = oam_rdata;
              2'd1: pb_d = oam_rdata;
              2'd2: pc_d = oam_rdata;
              2'd3: begin
                pd_d           = oam_rdata;
                state_d        = StIdle;
                cache_valid_d  = 1'b1;
                params_valid_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    oam_re    = (state_q == StFetch) && !issue_cnt_q[2];
    oam_addr  = oam_re ? {cached_group_q, issue_cnt_q[1:0], 2'b11} : 9'd0;
  end

  assign pa           = pa_q;
  assign pb           = pb_q;
  assign pc           = pc_q;
  assign pd           = pd_q;
  assign params_valid = params_valid_q;

endmodule

// File: doc/obj_affine_param_fetch.md
Name: obj_affine_param_fetch

Overview:
Fetches one OBJ affine parameter group (PA, PB, PC, PD) from OAM and presents it as the a/b/c/d operands consumed by the OBJ rotation/scale unit. The sprite engine requests a 5-bit group index. The block either reuses its one-entry cached group or issues four pipelined OAM halfword reads. It then holds the signed 8.8 fixed-point parameters stable under a valid flag until the next miss or flush.

Parameters:
OAM_LAT, 1, OAM read latency in cycles from oam_re to oam_rdata valid; legal values 1 or 2.

Ports:
clock  input  1  system clock
rst_n  input  1  synchronous active-low reset
req_valid  input  1  fetch request
req_ready  output  1  block can accept a request
req_group  input  5  affine parameter group index 0..31
flush  input  1  OAM was written; invalidate cache
oam_re  output  1  OAM read enable
oam_addr  output  9  OAM halfword address
oam_rdata  input  16  OAM read data, valid OAM_LAT cycles after oam_re
pa  output  16  PA, signed 8.8
pb  output  16  PB, signed 8.8
pc  output  16  PC, signed 8.8
pd  output  16  PD, signed 8.8
params_valid  output  1  pa..pd hold the group in cached_group

Behaviour:
- Reset, applied when rst_n is low at a clock edge:
  - state=IDLE, cache_valid=0, cached_group=0.
  - pa=16'h0100, pb=0, pc=0, pd=16'h0100 (identity).
  - params_valid=0, oam_re=0, oam_addr=0.
  - Reset mid-fetch abandons all in-flight reads and discards late oam_rdata.
- req_ready=1 only in IDLE, decoded from registered state; it is 1 in the first cycle after reset.
- Accept: req_valid & req_ready at an edge.
- Hit: cache_valid & req_group==cached_group & no flush in the same cycle.
  - State stays IDLE, no OAM access.
  - params_valid=1 from the next cycle.
  - pa..pd unchanged.
- Miss: any other accept.
  - cached_group<=req_group, cache_valid<=0, params_valid<=0 next cycle.
  - State goes to FETCH.
- FETCH, issue side:
  - issue_cnt k=0..3; one read per cycle, oam_re=1 for exactly 4 consecutive cycles.
  - oam_addr={cached_group, k[1:0], 2'b11}, i.e. group*16 + k*4 + 3 (attr3 of OAM entries 4g..4g+3).
- FETCH, capture side:
  - capture_cnt counts returning data OAM_LAT cycles after each issue.
  - k=0 goes to pa, 1 to pb, 2 to pc, 3 to pd.
  - Each register is written only on its own capture cycle.
- Completion, in the cycle after the pd capture:
  - state=IDLE, cache_valid=1, params_valid=1.
- Miss latency: accept at edge T means reads issued in cycles T+1..T+4 and params_valid high from T+5+OAM_LAT (6 for OAM_LAT=1).
- flush:
  - In IDLE: cache_valid<=0 and params_valid<=0 next cycle; pa..pd retain values.
  - In FETCH: restart with issue_cnt=0, in-flight returns discarded, cached_group kept; completion latency restarts from the flush edge.
  - Flush coincident with accept: treated as a miss.
- req_valid while FETCH is ignored (req_ready=0); requesters hold req_valid until accepted.
- oam_rdata is captured verbatim with no sign manipulation; sign handling belongs to the consumer.
- cached_group 31 wraps nothing: address 31*16+15=511 is the top OAM halfword.

Test Plan:
- Reset then idle: pa=0x0100, pd=0x0100, pb=pc=0, params_valid=0, req_ready=1, oam_re never asserted.
- Miss on group 5, OAM_LAT=1, OAM attr3 words 0x0200/0xFF80/0x0040/0x0180:
  - oam_addr 83,87,91,95 in consecutive cycles.
  - params_valid rises 6 cycles after accept with pa=0x0200, pb=0xFF80, pc=0x0040, pd=0x0180.
- Repeat request for group 5: no oam_re, params_valid=1 next cycle, values unchanged. Then group 31: addresses 499,503,507,511.
- flush asserted on the 3rd FETCH cycle: reads restart at k=0 with 4 fresh addresses; stale data is not captured; final values match OAM contents after the flush.
- rst_n low on the 2nd FETCH cycle: all outputs at reset values next cycle; late oam_rdata ignored; a following group-0 request performs a full miss.
- OAM_LAT=2 build: same as the group-5 miss, params_valid at accept+7; flush in IDLE then the same group forces a full refetch.
